// File: rtl/keypad_key_decoder.sv
// -----------------------------------------------------------------------------
// keypad_key_decoder
//
// Consumer end of the keypad scanner. Each one-cycle key_coord pulse
// {row[3:0], col[3:0]} (active-low one-hot nibbles) is decoded to a 4-bit key
// code in a capture stage, then written into a first-word-fall-through FIFO
// that the CPU drains with a valid/read handshake. Dropped keys (FIFO full)
// and undecodable coordinates raise sticky error flags.
//
// All state updates on the falling edge of clk, matching the scanner.
//
// Ports:
//   clk        system clock (falling-edge active)
//   rst_n      asynchronous active-low reset
//   key_coord  {row,col} from scanner; 8'h00 = no event
//   key_rd     pop request, honoured only while key_valid=1
//   clr_err    clears overflow and bad_coord (a coincident set wins)
//   key_data   code of the oldest queued key, 0 when empty
//   key_valid  FIFO non-empty
//   key_count  queued entries, 0..DEPTH
//   overflow   sticky: a decoded key was dropped because the FIFO was full
//   bad_coord  sticky: a nonzero coordinate could not be decoded
// -----------------------------------------------------------------------------
module keypad_key_decoder #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        key_coord,
    input  logic              key_rd,
    input  logic              clr_err,
    output logic [3:0]        key_data,
    output logic              key_valid,
    output logic [ADDR_W:0]   key_count,
    output logic              overflow,
    output logic              bad_coord
);

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    // Decode signals
    logic [1:0]        w_row_idx;
    logic [1:0]        w_col_idx;
    logic              w_row_ok;
    logic              w_col_ok;
    logic [3:0]        w_code;
    logic              w_event;
    logic              w_good;
    logic              w_bad;

    // FIFO control
    logic              w_full;
    logic              w_pop;
    logic              w_push;

    // State
    logic [3:0]        r_s1_code;
    logic              r_s1_pend;
    logic [3:0]        r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_overflow;
    logic              r_bad_coord;

    // NOTE: every combinational output gets a default first so no path through
    // the case statements leaves it unassigned, which would infer a latch.
    always_comb begin
        w_row_idx = 2'd0;
        w_row_ok  = 1'b1;
        case (key_coord[7:4])
            4'b0111: w_row_idx = 2'd0;
            4'b1011: w_row_idx = 2'd1;
            4'b1101: w_row_idx = 2'd2;
            4'b1110: w_row_idx = 2'd3;
            default: w_row_ok  = 1'b0;
        endcase

        w_col_idx = 2'd0;
        w_col_ok  = 1'b1;
        case (key_coord[3:0])
            4'b0111: w_col_idx = 2'd0;
            4'b1011: w_col_idx = 2'd1;
            4'b1101: w_col_idx = 2'd2;
            4'b1110: w_col_idx = 2'd3;
            default: w_col_ok  = 1'b0;
        endcase

        // Telephone-style layout; '*' maps to E and '#' to F.
        w_code = 4'h0;
        case ({w_row_idx, w_col_idx})
            4'd0:  w_code = 4'h1;
            4'd1:  w_code = 4'h2;
            4'd2:  w_code = 4'h3;
            4'd3:  w_code = 4'hA;
            4'd4:  w_code = 4'h4;
            4'd5:  w_code = 4'h5;
            4'd6:  w_code = 4'h6;
            4'd7:  w_code = 4'hB;
            4'd8:  w_code = 4'h7;
            4'd9:  w_code = 4'h8;
            4'd10: w_code = 4'h9;
            4'd11: w_code = 4'hC;
            4'd12: w_code = 4'hE;
            4'd13: w_code = 4'h0;
            4'd14: w_code = 4'hF;
            default: w_code = 4'hD;
        endcase
    end

    assign w_event = (key_coord != 8'h00);
    assign w_good  = w_event && w_row_ok && w_col_ok;
    assign w_bad   = w_event && !(w_row_ok && w_col_ok);

    // Full/empty come from the count so pointer wrap needs no extra bit.
    assign w_full  = (r_count == L_DEPTH);
    assign w_pop   = key_valid && key_rd;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push  = r_s1_pend && (!w_full || w_pop);

    // Capture stage: one register per event, no merging of adjacent pulses.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_code <= 4'h0;
            r_s1_pend <= 1'b0;
        end else begin
            r_s1_pend <= w_good;
            if (w_good) begin
                r_s1_code <= w_code;
            end
        end
    end

    // Pointers and occupancy.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (ADDR_W+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (ADDR_W+1)'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; the count gates every read, so
    // stale contents are never visible and the array can map to plain RAM.
    always_ff @(negedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_s1_code;
        end
    end

    // Sticky error flags: set has priority over clear.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_bad_coord <= 1'b0;
        end else begin
            if (r_s1_pend && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_bad) begin
                r_bad_coord <= 1'b1;
            end else if (clr_err) begin
                r_bad_coord <= 1'b0;
            end
        end
    end

    assign key_valid = (r_count != '0);
    assign key_data  = key_valid ? r_mem[r_rd_ptr] : 4'h0;
    assign key_count = r_count;
    assign overflow  = r_overflow;
    assign bad_coord = r_bad_coord;

endmodule

// File: tb/tb_keypad_key_decoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_key_decoder
//
// Directed stimulus with a scoreboard: every key expected to reach the FIFO
// has its code pushed into exp_q when the pulse is issued; a separate monitor
// pops exp_q and compares key_data whenever a read is accepted. Occupancy and
// flag checks are made inline. The DUT acts on the falling edge; inputs change
// 1 time unit after each falling edge and outputs are sampled on rising edges
// or mid-cycle.
// -----------------------------------------------------------------------------
module tb_keypad_key_decoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] key_coord;
    logic       key_rd;
    logic       clr_err;
    logic [3:0] key_data;
    logic       key_valid;
    logic [3:0] key_count;
    logic       overflow;
    logic       bad_coord;

    int         total;
    int         bad;
    logic [3:0] exp_q [$];

    keypad_key_decoder #(.DEPTH(8), .ADDR_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_coord (key_coord),
        .key_rd    (key_rd),
        .clr_err   (clr_err),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_count (key_count),
        .overflow  (overflow),
        .bad_coord (bad_coord)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Advance to 1 unit after the next active (falling) edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // One-cycle coordinate pulse; returns just after its capture edge.
    task automatic send(input logic [7:0] coord);
        key_coord = coord;
        step(1);
        key_coord = 8'h00;
    endtask

    task automatic pop_one();
        key_rd = 1'b1;
        step(1);
        key_rd = 1'b0;
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
    endtask

    // Monitor: compare the head on every accepted read.
    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && key_rd && key_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got %0h expected none", key_data);
                end else begin
                    check("pop_data", int'(key_data), int'(exp_q.pop_front()));
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        logic [7:0] fill [10];
        fill = '{8'h77, 8'h7B, 8'h7D, 8'hB7, 8'hBB, 8'hBD, 8'hD7, 8'hDB, 8'hDD, 8'h7E};
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        key_coord = 8'h00;
        key_rd    = 1'b0;
        clr_err   = 1'b0;

        // Reset state
        #2;
        check("rst_valid", int'(key_valid), 0);
        check("rst_data",  int'(key_data),  0);
        check("rst_count", int'(key_count), 0);
        check("rst_ovf",   int'(overflow),  0);
        check("rst_bad",   int'(bad_coord), 0);
        @(posedge clk);
        rst_n = 1'b1;
        step(1);

        // Single key, 2-edge latency, then pop
        exp_q.push_back(4'h1);
        send(8'h77);
        check("lat_valid_early", int'(key_valid), 0);
        step(1);
        check("t1_valid", int'(key_valid), 1);
        check("t1_data",  int'(key_data),  4'h1);
        check("t1_count", int'(key_count), 1);
        pop_one();
        check("t1_valid_after", int'(key_valid), 0);
        check("t1_data_after",  int'(key_data),  0);
        check("t1_count_after", int'(key_count), 0);

        // Row 3 keys back-to-back: E, 0, F, D
        exp_q.push_back(4'hE); send(8'hE7);
        exp_q.push_back(4'h0); send(8'hEB);
        exp_q.push_back(4'hF); send(8'hED);
        exp_q.push_back(4'hD); send(8'hEE);
        step(1);
        check("t2_count", int'(key_count), 4);
        for (int i = 3; i >= 0; i--) begin
            pop_one();
            check("t2_count_pop", int'(key_count), i);
        end

        // Ten keys into an 8-deep FIFO: 9 and A are dropped
        for (int i = 0; i < 10; i++) begin
            if (i < 8) exp_q.push_back(4'(i + 1));
            send(fill[i]);
        end
        step(1);
        check("t3_count", int'(key_count), 8);
        check("t3_ovf",   int'(overflow),  1);
        clear_errors();
        check("t3_ovf_clr", int'(overflow), 0);

        // Full FIFO, new key reaches the write edge together with a read
        send(8'hBE);            // key B, now pending
        key_rd = 1'b1;          // pop on the same edge as the write
        step(1);
        key_rd = 1'b0;
        exp_q.push_back(4'hB);
        check("t4_ovf",   int'(overflow),  0);
        check("t4_count", int'(key_count), 8);
        for (int i = 0; i < 8; i++) pop_one();
        check("t4_count_empty", int'(key_count), 0);

        // Malformed coordinates
        send(8'h33);
        send(8'hF7);
        send(8'h7F);
        step(1);
        check("t5_count", int'(key_count), 0);
        check("t5_valid", int'(key_valid), 0);
        check("t5_bad",   int'(bad_coord), 1);
        key_coord = 8'h33;
        clr_err   = 1'b1;
        step(1);
        key_coord = 8'h00;
        clr_err   = 1'b0;
        check("t5_set_wins", int'(bad_coord), 1);
        clear_errors();
        check("t5_bad_clr", int'(bad_coord), 0);

        // Asynchronous reset mid-operation, set overflow first to see it clear
        for (int i = 0; i < 9; i++) send(fill[i]);
        step(1);
        check("t6_count_pre", int'(key_count), 8);
        check("t6_ovf_pre",   int'(overflow),  1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_rst_valid", int'(key_valid), 0);
        check("t6_rst_data",  int'(key_data),  0);
        check("t6_rst_count", int'(key_count), 0);
        check("t6_rst_ovf",   int'(overflow),  0);
        #3;
        rst_n = 1'b1;
        step(1);
        exp_q.push_back(4'h4);
        send(8'hB7);
        step(1);
        check("t6_data",  int'(key_data),  4'h4);
        check("t6_count", int'(key_count), 1);
        pop_one();
        check("t6_count_end", int'(key_count), 0);
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
